// File: rtl/alu_cmd_sequencer.sv
// Valid/ready command sequencer for a 7-bit combinational ALU with a chaining accumulator.
// Optional sticky overflow flag (ports sticky_ovf/clr_sticky) built when ALU_SEQ_STICKY_EN is defined.
module alu_cmd_sequencer #(
   parameter int ALU_LATENCY = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [6:0] cmd_a,
   input  logic [6:0] cmd_b,
   input  logic       cmd_use_acc,
   input  logic       cmd_wr_acc,
   output logic [6:0] alu_a,
   output logic [6:0] alu_b,
   output logic [2:0] alu_opsel,
   input  logic [6:0] alu_result,
   input  logic       alu_carry,
   input  logic       alu_overflow,
   input  logic       alu_zero,
   input  logic       alu_negative,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [6:0] rsp_result,
   output logic [3:0] rsp_flags,
   output logic       rsp_err,
`ifdef ALU_SEQ_STICKY_EN
   output logic       sticky_ovf,
   input  logic       clr_sticky,
`endif
   output logic [6:0] acc
);

   if (ALU_LATENCY < 1 || ALU_LATENCY > 4) begin : g_bad_latency
      $error("alu_cmd_sequencer: ALU_LATENCY must be in 1..4");
   end

   localparam logic [1:0] LAT_M1 = 2'(ALU_LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t     state_r, state_s;
   logic [1:0] cnt_r, cnt_s;
   logic       wr_acc_r, wr_acc_s;
   logic       err_r, err_s;
   logic       capture_s;
   logic       cmd_ready_s, rsp_valid_s, rsp_err_s;
   logic [6:0] alu_a_s, alu_b_s, rsp_result_s, acc_s;
   logic [2:0] alu_opsel_s;
   logic [3:0] rsp_flags_s;

   // State, counter and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         cnt_r      <= 2'd0;
         wr_acc_r   <= 1'b0;
         err_r      <= 1'b0;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         alu_a      <= 7'd0;
         alu_b      <= 7'd0;
         alu_opsel  <= 3'd0;
         rsp_result <= 7'd0;
         rsp_flags  <= 4'd0;
         rsp_err    <= 1'b0;
         acc        <= 7'd0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         wr_acc_r   <= wr_acc_s;
         err_r      <= err_s;
         cmd_ready  <= cmd_ready_s;
         rsp_valid  <= rsp_valid_s;
         alu_a      <= alu_a_s;
         alu_b      <= alu_b_s;
         alu_opsel  <= alu_opsel_s;
         rsp_result <= rsp_result_s;
         rsp_flags  <= rsp_flags_s;
         rsp_err    <= rsp_err_s;
         acc        <= acc_s;
      end
   end

   // Next-state and next-output logic; every register holds unless its state acts on it.
   always_comb begin
      state_s      = state_r;
      cnt_s        = cnt_r;
      wr_acc_s     = wr_acc_r;
      err_s        = err_r;
      capture_s    = 1'b0;
      alu_a_s      = alu_a;
      alu_b_s      = alu_b;
      alu_opsel_s  = alu_opsel;
      rsp_result_s = rsp_result;
      rsp_flags_s  = rsp_flags;
      rsp_err_s    = rsp_err;
      acc_s        = acc;
      case (state_r)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               alu_a_s     = cmd_use_acc ? acc : cmd_a;
               alu_b_s     = cmd_b;
               alu_opsel_s = cmd_op;
               wr_acc_s    = cmd_wr_acc;
               err_s       = (cmd_op >= 3'b110);
               cnt_s       = LAT_M1;
               state_s     = ST_EXEC;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_EXEC: begin
            if (cnt_r == 2'd0) begin
               capture_s    = 1'b1;
               rsp_result_s = alu_result;
               rsp_flags_s  = {alu_negative, alu_zero, alu_overflow, alu_carry};
               rsp_err_s    = err_r;
               // Illegal opcodes never touch the accumulator.
               if (wr_acc_r && !err_r) begin
                  acc_s = alu_result;
               end else begin
                  acc_s = acc;
               end
               state_s = ST_RESP;
            end else begin
               cnt_s   = cnt_r - 2'd1;
               state_s = ST_EXEC;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_s = ST_IDLE;
            end else begin
               state_s = ST_RESP;
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
      cmd_ready_s = (state_s == ST_IDLE);
      rsp_valid_s = (state_s == ST_RESP);
   end

`ifdef ALU_SEQ_STICKY_EN
   // Sticky overflow: a capture with overflow takes priority over a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_ovf <= 1'b0;
      end else if (capture_s && alu_overflow) begin
         sticky_ovf <= 1'b1;
      end else if (clr_sticky) begin
         sticky_ovf <= 1'b0;
      end else begin
         sticky_ovf <= sticky_ovf;
      end
   end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer at ALU_LATENCY 1, 3 and 4, with a behavioural ALU.
// Sticky-overflow checks run when ALU_SEQ_STICKY_EN is defined.
module tb_alu_cmd_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] cmd_valid;
   logic [2:0] cmd_ready;
   logic [2:0] cmd_op;
   logic [6:0] cmd_a, cmd_b;
   logic       cmd_use_acc, cmd_wr_acc;
   logic [6:0] alu_a [3];
   logic [6:0] alu_b [3];
   logic [2:0] alu_opsel [3];
   logic [10:0] alu_out [3];
   logic [2:0] rsp_valid;
   logic [2:0] rsp_ready;
   logic [6:0] rsp_result [3];
   logic [3:0] rsp_flags [3];
   logic [2:0] rsp_err;
   logic [6:0] acc [3];
   logic [2:0] sticky_ovf;
   logic [2:0] clr_sticky;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   // Reference 7-bit ALU: returns {negative, zero, overflow, carry, result}.
   function automatic logic [10:0] alu_fn(input logic [2:0] op, input logic [6:0] a, input logic [6:0] b);
      logic [7:0] w;
      logic       o;
      w = 8'd0;
      o = 1'b0;
      case (op)
         3'b000: begin
            w = {1'b0, a} + {1'b0, b};
            o = (a[6] == b[6]) && (w[6] != a[6]);
         end
         3'b001: begin
            w = {1'b0, a} + {1'b0, ~b} + 8'd1;
            o = (a[6] != b[6]) && (w[6] != a[6]);
         end
         3'b010: w = {1'b0, a & b};
         3'b011: w = {1'b0, a | b};
         3'b100: w = {b[6], b[5:0], 1'b0};
         3'b101: w = {b[0], 1'b0, b[6:1]};
         default: w = 8'd0;
      endcase
      return {w[6], (w[6:0] == 7'd0), o, w[7], w[6:0]};
   endfunction

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         alu_out[i] = alu_fn(alu_opsel[i], alu_a[i], alu_b[i]);
      end
   end

   alu_cmd_sequencer #(.ALU_LATENCY(1)) u_dut_l1 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc),
      .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_opsel(alu_opsel[0]),
      .alu_result(alu_out[0][6:0]), .alu_carry(alu_out[0][7]), .alu_overflow(alu_out[0][8]),
      .alu_zero(alu_out[0][9]), .alu_negative(alu_out[0][10]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
      .rsp_flags(rsp_flags[0]), .rsp_err(rsp_err[0]),
`ifdef ALU_SEQ_STICKY_EN
      .sticky_ovf(sticky_ovf[0]), .clr_sticky(clr_sticky[0]),
`endif
      .acc(acc[0]));

   alu_cmd_sequencer #(.ALU_LATENCY(3)) u_dut_l3 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc),
      .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_opsel(alu_opsel[1]),
      .alu_result(alu_out[1][6:0]), .alu_carry(alu_out[1][7]), .alu_overflow(alu_out[1][8]),
      .alu_zero(alu_out[1][9]), .alu_negative(alu_out[1][10]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
      .rsp_flags(rsp_flags[1]), .rsp_err(rsp_err[1]),
`ifdef ALU_SEQ_STICKY_EN
      .sticky_ovf(sticky_ovf[1]), .clr_sticky(clr_sticky[1]),
`endif
      .acc(acc[1]));

   alu_cmd_sequencer #(.ALU_LATENCY(4)) u_dut_l4 (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
      .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc), .cmd_wr_acc(cmd_wr_acc),
      .alu_a(alu_a[2]), .alu_b(alu_b[2]), .alu_opsel(alu_opsel[2]),
      .alu_result(alu_out[2][6:0]), .alu_carry(alu_out[2][7]), .alu_overflow(alu_out[2][8]),
      .alu_zero(alu_out[2][9]), .alu_negative(alu_out[2][10]),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_result(rsp_result[2]),
      .rsp_flags(rsp_flags[2]), .rsp_err(rsp_err[2]),
`ifdef ALU_SEQ_STICKY_EN
      .sticky_ovf(sticky_ovf[2]), .clr_sticky(clr_sticky[2]),
`endif
      .acc(acc[2]));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_cmd(input logic [2:0] op, input logic [6:0] a, input logic [6:0] b,
                          input logic use_acc, input logic wr_acc);
      cmd_op      = op;
      cmd_a       = a;
      cmd_b       = b;
      cmd_use_acc = use_acc;
      cmd_wr_acc  = wr_acc;
   endtask

   initial begin
      rst = 1'b1;
      cmd_valid = 3'b000;
      rsp_ready = 3'b000;
      clr_sticky = 3'b000;
      set_cmd(3'b000, 7'h00, 7'h00, 1'b0, 1'b0);
      repeat (2) tick();
      chk("rst_alu_a", alu_a[0], 7'h00);
      chk("rst_opsel", alu_opsel[0], 3'd0);
      chk("rst_rsp_valid", rsp_valid, 3'b000);
      chk("rst_rsp_result", rsp_result[0], 7'h00);
      chk("rst_rsp_flags", rsp_flags[0], 4'h0);
      chk("rst_rsp_err", rsp_err, 3'b000);
      chk("rst_acc", acc[0], 7'h00);
      rst = 1'b0;
      tick();
      chk("rst_cmd_ready", cmd_ready, 3'b111);

      // Add 7F+01 at latency 1
      rsp_ready[0] = 1'b1;
      set_cmd(3'b000, 7'h7F, 7'h01, 1'b0, 1'b0);
      cmd_valid[0] = 1'b1;
      tick();
      cmd_valid[0] = 1'b0;
      chk("add_busy_ready", cmd_ready[0], 1'b0);
      chk("add_no_rsp_yet", rsp_valid[0], 1'b0);
      chk("add_alu_a", alu_a[0], 7'h7F);
      chk("add_alu_b", alu_b[0], 7'h01);
      chk("add_opsel", alu_opsel[0], 3'b000);
      tick();
      chk("add_rsp_valid", rsp_valid[0], 1'b1);
      chk("add_result", rsp_result[0], 7'h00);
      chk("add_flags", rsp_flags[0], 4'b0101);
      chk("add_err", rsp_err[0], 1'b0);
      tick();
      chk("add_rsp_drop", rsp_valid[0], 1'b0);
      chk("add_ready_back", cmd_ready[0], 1'b1);
      chk("add_alu_a_hold", alu_a[0], 7'h7F);

      // Write acc=40 then subtract 1 from acc
      set_cmd(3'b011, 7'h40, 7'h00, 1'b0, 1'b1);
      cmd_valid[0] = 1'b1;
      tick();
      cmd_valid[0] = 1'b0;
      tick();
      chk("or_acc", acc[0], 7'h40);
      chk("or_result", rsp_result[0], 7'h40);
      chk("or_flags", rsp_flags[0], 4'b1000);
      tick();
      set_cmd(3'b001, 7'h00, 7'h01, 1'b1, 1'b0);
      cmd_valid[0] = 1'b1;
      tick();
      cmd_valid[0] = 1'b0;
      chk("sub_alu_a_acc", alu_a[0], 7'h40);
      tick();
      chk("sub_result", rsp_result[0], 7'h3F);
      chk("sub_flags", rsp_flags[0], 4'b0011);
      chk("sub_acc_kept", acc[0], 7'h40);
      tick();

      // Illegal opcode with wr_acc
      set_cmd(3'b110, 7'h12, 7'h34, 1'b0, 1'b1);
      cmd_valid[0] = 1'b1;
      tick();
      cmd_valid[0] = 1'b0;
      chk("ill_opsel", alu_opsel[0], 3'b110);
      tick();
      chk("ill_rsp_valid", rsp_valid[0], 1'b1);
      chk("ill_err", rsp_err[0], 1'b1);
      chk("ill_result", rsp_result[0], 7'h00);
      chk("ill_flags", rsp_flags[0], 4'b0100);
      chk("ill_acc", acc[0], 7'h40);
      tick();

      // Backpressure at latency 3, cmd_valid held high throughout
      rsp_ready[1] = 1'b0;
      set_cmd(3'b000, 7'h05, 7'h03, 1'b0, 1'b0);
      cmd_valid[1] = 1'b1;
      tick();
      chk("bp_alu_a", alu_a[1], 7'h05);
      for (int k = 0; k < 2; k++) begin
         tick();
         chk("bp_no_early_rsp", rsp_valid[1], 1'b0);
      end
      tick();
      chk("bp_capture", rsp_valid[1], 1'b1);
      chk("bp_result", rsp_result[1], 7'h08);
      cmd_a = 7'h10;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("bp_hold_valid", rsp_valid[1], 1'b1);
         chk("bp_hold_result", rsp_result[1], 7'h08);
         chk("bp_hold_flags", rsp_flags[1], 4'b0000);
         chk("bp_no_accept", cmd_ready[1], 1'b0);
         chk("bp_alu_a_hold", alu_a[1], 7'h05);
      end
      rsp_ready[1] = 1'b1;
      tick();
      chk("bp_release_valid", rsp_valid[1], 1'b0);
      chk("bp_release_ready", cmd_ready[1], 1'b1);
      tick();
      cmd_valid[1] = 1'b0;
      chk("bp_second_accept", cmd_ready[1], 1'b0);
      chk("bp_second_alu_a", alu_a[1], 7'h10);
      tick();
      tick();
      chk("bp_second_wait", rsp_valid[1], 1'b0);
      tick();
      chk("bp_second_rsp", rsp_valid[1], 1'b1);
      chk("bp_second_result", rsp_result[1], 7'h13);
      tick();

      // Reset two cycles into EXEC at latency 4
      rsp_ready[2] = 1'b1;
      set_cmd(3'b000, 7'h01, 7'h02, 1'b0, 1'b1);
      cmd_valid[2] = 1'b1;
      tick();
      cmd_valid[2] = 1'b0;
      tick();
      tick();
      chk("mid_still_exec", rsp_valid[2], 1'b0);
      chk("mid_alu_a", alu_a[2], 7'h01);
      rst = 1'b1;
      #1;
      chk("mid_rst_alu_a", alu_a[2], 7'h00);
      chk("mid_rst_alu_b", alu_b[2], 7'h00);
      chk("mid_rst_opsel", alu_opsel[2], 3'd0);
      chk("mid_rst_rsp_valid", rsp_valid, 3'b000);
      chk("mid_rst_acc0", acc[0], 7'h00);
      chk("mid_rst_acc2", acc[2], 7'h00);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("post_rst_no_rsp", rsp_valid[2], 1'b0);
         chk("post_rst_acc", acc[2], 7'h00);
         chk("post_rst_ready", cmd_ready[2], 1'b1);
      end

`ifdef ALU_SEQ_STICKY_EN
      chk("sticky_rst", sticky_ovf[0], 1'b0);
      set_cmd(3'b001, 7'h40, 7'h01, 1'b0, 1'b0);
      cmd_valid[0] = 1'b1;
      tick();
      cmd_valid[0] = 1'b0;
      tick();
      chk("sticky_set", sticky_ovf[0], 1'b1);
      tick();
      set_cmd(3'b000, 7'h01, 7'h01, 1'b0, 1'b0);
      cmd_valid[0] = 1'b1;
      tick();
      cmd_valid[0] = 1'b0;
      tick();
      chk("sticky_keep", sticky_ovf[0], 1'b1);
      tick();
      clr_sticky[0] = 1'b1;
      tick();
      clr_sticky[0] = 1'b0;
      chk("sticky_clr", sticky_ovf[0], 1'b0);
      set_cmd(3'b001, 7'h40, 7'h01, 1'b0, 1'b0);
      cmd_valid[0] = 1'b1;
      tick();
      cmd_valid[0] = 1'b0;
      clr_sticky[0] = 1'b1;
      tick();
      clr_sticky[0] = 1'b0;
      chk("sticky_set_wins", sticky_ovf[0], 1'b1);
      tick();
      chk("sticky_after", sticky_ovf[0], 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command-side initiator for the 7-bit combinational ALU: accepts operation requests on a valid/ready command port and drives the ALU's A, B and OpSel inputs.
- Waits a configurable settle time, captures the ALU's Result, CarryOut, Overflow, Zero and Negative, and returns them on a valid/ready response port.
- Holds a 7-bit accumulator that can replace A and can be written with the result, so the datapath can chain operations.

Parameters:
- ALU_LATENCY, 1, cycles operands are held on alu_* before result capture; legal 1..4; values outside this range are a compile-time error.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept command
- cmd_op  input  3  ALU opcode (000 add, 001 sub, 010 and, 011 or, 100 shl B, 101 shr B)
- cmd_a  input  7  operand A
- cmd_b  input  7  operand B
- cmd_use_acc  input  1  1: use accumulator as A instead of cmd_a
- cmd_wr_acc  input  1  1: write captured result into accumulator
- alu_a  output  7  to ALU A
- alu_b  output  7  to ALU B
- alu_opsel  output  3  to ALU OpSel
- alu_result  input  7  from ALU Result
- alu_carry  input  1  from ALU CarryOut
- alu_overflow  input  1  from ALU Overflow
- alu_zero  input  1  from ALU Zero
- alu_negative  input  1  from ALU Negative
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_result  output  7  captured result
- rsp_flags  output  4  {negative, zero, overflow, carry}
- rsp_err  output  1  illegal opcode (110/111)
- acc  output  7  current accumulator value

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE; acc, alu_a, alu_b, alu_opsel, rsp_result, rsp_flags, rsp_err and rsp_valid all 0; cmd_ready 1 once rst deasserts.
- States are IDLE, EXEC and RESP. cmd_ready=1 only in IDLE. rsp_valid=1 only in RESP.
- IDLE:
  - On the edge with cmd_valid&cmd_ready, register alu_a (acc if cmd_use_acc, else cmd_a), alu_b=cmd_b and alu_opsel=cmd_op.
  - Latch wr_acc and err (cmd_op>=110), load the wait counter with ALU_LATENCY-1, and go to EXEC.
- EXEC:
  - alu_* are held stable throughout.
  - The counter decrements each cycle. On the edge where the counter is 0, capture alu_result and the flags into rsp_* and go to RESP.
  - If wr_acc is set and err is clear, the same edge writes acc<=alu_result.
- RESP:
  - rsp_* are held stable while rsp_valid=1 and rsp_ready=0.
  - On the edge with rsp_ready=1, go to IDLE. rsp_valid falls and cmd_ready rises after that edge.
- Timing:
  - Accept at edge N; capture at edge N+ALU_LATENCY; rsp_valid high from edge N+ALU_LATENCY.
  - Minimum issue interval is ALU_LATENCY+2 cycles. With ALU_LATENCY=1 and rsp_ready tied high, a command every 3 cycles.
- Illegal opcode:
  - Still issued to the ALU, which returns result 0 and zero flag 1; these are captured as-is.
  - rsp_err=1 and acc is not modified.
- alu_* keep their last values in IDLE and RESP; no glitching between commands.
- cmd_* are sampled only on the accept edge. Changes at other times are ignored.
- Reset asserted in any state returns immediately to the reset values. Any in-flight command is dropped, with no response and no acc write.
- rsp_ready asserted outside RESP has no effect.
- Accumulator arithmetic is 7-bit and wraps naturally. Carry and overflow come only from the ALU; there is no sign extension.

Optional Feature:
- Macro ALU_SEQ_STICKY_EN.
- When defined, adds port sticky_ovf (output, 1) and port clr_sticky (input, 1).
  - sticky_ovf sets on any capture edge with alu_overflow=1 and stays set until clr_sticky=1 or rst.
  - If set and clear happen on the same edge, set wins.
  - sticky_ovf resets to 0.
- When undefined, neither port exists and no sticky logic is built.

Test Plan:
- Add, ALU_LATENCY=1: cmd_op=000, a=7F, b=01, rsp_ready=1 -> rsp_result=00, rsp_flags=0101 (zero, carry), rsp_valid exactly 1 edge after accept, rsp_err=0.
- Sub from accumulator: first write acc=40 (op 011, a=40, b=00, wr_acc=1), then op 001, use_acc=1, b=01 -> alu_a=40; rsp_result=3F, flags=0011 (overflow, carry).
- Backpressure, ALU_LATENCY=3: hold rsp_ready=0 for 5 cycles after rsp_valid -> rsp_* stable, cmd_ready=0 throughout; accept occurs only after the rsp_ready edge; capture occurs 3 edges after accept.
- Illegal opcode: op 110, a=12, b=34, wr_acc=1 -> rsp_err=1, rsp_result=00, flags=0100, acc unchanged.
- Reset mid-EXEC: assert rst with ALU_LATENCY=4 two cycles after accept -> all outputs immediately return to reset values, no rsp_valid, acc=00, cmd_ready=1 after release.
- ALU_SEQ_STICKY_EN: overflowing sub followed by non-overflowing add -> sticky_ovf stays 1; pulse clr_sticky -> sticky_ovf 0; clr_sticky on the same edge as an overflow capture -> sticky_ovf stays 1.
